// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
//   Multi-cycle 16x16->32 unsigned shift-and-add multiplier. It accepts an
//   operand pair over a valid/ready handshake and drives one external
//   combinational alu_16bit instance for the duration of the operation. The
//   ALU result is captured on the next rising edge. The 32-bit product is
//   returned over a second valid/ready handshake.
//
//   Each multiplier bit takes two cycles:
//     ADD   : hi + (lo[0] ? a : 0) -> {c,hi}
//     SHIFT : ALU right-shift of hi with carry_in = c gives {c,hi[15:1]};
//             lo shifts right with hi[0] entering at the top.
//   Sixteen {ADD,SHIFT} pairs give a fixed 32-cycle latency that does not
//   depend on the data.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   req_valid/ready operand handshake; req_ready is high only in IDLE
//   req_a, req_b    multiplicand, multiplier
//   res_valid/ready product handshake; res_valid is high only in DONE
//   res_product     {hi,lo} product, held stable while waiting for res_ready
//   alu_args        {d1,d2} to alu_16bit
//   alu_carry_in    carry_in to alu_16bit
//   alu_carry_dis   carry_disable to alu_16bit
//   alu_cmd         cmd to alu_16bit
//   alu_res         res from alu_16bit
//   alu_carry_out   carry_out from alu_16bit
// -----------------------------------------------------------------------------
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_a,
    input  logic [WIDTH-1:0]     req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   res_product,
    output logic [2*WIDTH-1:0]   alu_args,
    output logic                 alu_carry_in,
    output logic                 alu_carry_dis,
    output logic [1:0]           alu_cmd,
    input  logic [WIDTH-1:0]     alu_res,
    input  logic                 alu_carry_out
);

    // The datapath is tied to the 16-bit ALU it drives.
    if (WIDTH != 16) begin : g_width_chk
        $error("alu_mul_seq: WIDTH must be 16 (alu_16bit width)");
    end

    // AluCtrl encodings: full add with carry enabled, and right shift.
    localparam logic       CTRL_ADD_DIS   = 1'b0;
    localparam logic [1:0] CTRL_ADD_CMD   = 2'b00;
    localparam logic       CTRL_RSHFT_DIS = 1'b1;
    localparam logic [1:0] CTRL_RSHFT_CMD = 2'b11;

    localparam logic [4:0] LAST_BIT = 5'd15;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ADD   = 2'b01,
        S_SHIFT = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q,  a_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             c_q,  c_d;
    logic [4:0]       cnt_q, cnt_d;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= {WIDTH{1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            c_q     <= 1'b0;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, datapath update and output decode. ALU drive depends only
    // on state and registers, so req_* and res_ready have no path to alu_*.
    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        c_d           = c_q;
        cnt_d         = cnt_q;
        req_ready     = 1'b0;
        res_valid     = 1'b0;
        res_product   = {(2*WIDTH){1'b0}};
        alu_args      = {(2*WIDTH){1'b0}};
        alu_carry_in  = 1'b0;
        alu_carry_dis = CTRL_ADD_DIS;
        alu_cmd       = CTRL_ADD_CMD;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    a_d     = req_a;
                    lo_d    = req_b;
                    hi_d    = {WIDTH{1'b0}};
                    c_d     = 1'b0;
                    cnt_d   = 5'd0;
                    state_d = S_ADD;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_ADD: begin
                // d1 = hi, d2 = multiplicand gated by the current multiplier bit.
                alu_args = {hi_q, (lo_q[0] ? a_q : {WIDTH{1'b0}})};
                hi_d     = alu_res;
                c_d      = alu_carry_out;
                state_d  = S_SHIFT;
            end

            S_SHIFT: begin
                // The ALU shifts {c,hi} right by one; the bit falling out of hi
                // enters the top of lo.
                alu_args      = {{WIDTH{1'b0}}, hi_q};
                alu_carry_in  = c_q;
                alu_carry_dis = CTRL_RSHFT_DIS;
                alu_cmd       = CTRL_RSHFT_CMD;
                hi_d          = alu_res;
                lo_d          = {hi_q[0], lo_q[WIDTH-1:1]};
                c_d           = 1'b0;
                cnt_d         = cnt_q + 5'd1;
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ADD;
                end
            end

            S_DONE: begin
                res_valid   = 1'b1;
                res_product = {hi_q, lo_q};
                if (res_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_a = 16'h0;
    logic [15:0] req_b = 16'h0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_product;
    logic [31:0] alu_args;
    logic        alu_carry_in;
    logic        alu_carry_dis;
    logic [1:0]  alu_cmd;
    logic [15:0] alu_res;
    logic        alu_carry_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_mul_seq #(.WIDTH(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_product   (res_product),
        .alu_args      (alu_args),
        .alu_carry_in  (alu_carry_in),
        .alu_carry_dis (alu_carry_dis),
        .alu_cmd       (alu_cmd),
        .alu_res       (alu_res),
        .alu_carry_out (alu_carry_out)
    );

    // Behavioural alu_16bit: ADD (carry enabled, cmd 00) and RSHFT (carry disabled, cmd 11).
    logic [16:0] alu_sum;
    always_comb begin
        alu_sum       = 17'h0;
        alu_res       = 16'h0;
        alu_carry_out = 1'b0;
        if (!alu_carry_dis && alu_cmd == 2'b00) begin
            alu_sum       = {1'b0, alu_args[31:16]} + {1'b0, alu_args[15:0]} + {16'h0, alu_carry_in};
            alu_res       = alu_sum[15:0];
            alu_carry_out = alu_sum[16];
        end else if (alu_carry_dis && alu_cmd == 2'b11) begin
            alu_res       = {alu_carry_in, alu_args[15:1]};
            alu_carry_out = alu_args[0];
        end else begin
            alu_res       = 16'h0;
            alu_carry_out = 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: idle / busy for 32 cycles / done, product = a*b.
    int          m_phase = 0;
    int          m_cnt   = 0;
    logic [31:0] m_prod  = 32'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_prod  <= 32'h0;
        end else begin
            case (m_phase)
                0: if (req_valid) begin
                    m_phase <= 1;
                    m_cnt   <= 0;
                    m_prod  <= 32'(req_a) * 32'(req_b);
                end
                1: begin
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == 31) m_phase <= 2;
                end
                default: if (res_ready) m_phase <= 0;
            endcase
        end
    end

    // Per-cycle comparison of the handshake and product against the model.
    always @(negedge clk) begin
        check("cyc_req_ready", {63'h0, req_ready}, {63'h0, (m_phase == 0)});
        check("cyc_res_valid", {63'h0, res_valid}, {63'h0, (m_phase == 2)});
        if (m_phase == 2) begin
            check("cyc_product", {32'h0, res_product}, {32'h0, m_prod});
        end
        if (m_phase == 0) begin
            check("idle_alu", {29'h0, alu_args, alu_carry_in, alu_carry_dis, alu_cmd},
                  {29'h0, 32'h0, 1'b0, 1'b0, 2'b00});
        end
    end

    task automatic mul(input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input int stall);
        int w;
        int lat;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("accept_ready", {63'h0, req_ready}, 64'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'd32);
        check("product", {32'h0, res_product}, {32'h0, exp});
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_valid", {63'h0, res_valid}, 64'h1);
            check("stall_ready", {63'h0, req_ready}, 64'h0);
            check("stall_product", {32'h0, res_product}, {32'h0, exp});
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("post_valid", {63'h0, res_valid}, 64'h0);
        check("post_ready", {63'h0, req_ready}, 64'h1);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        #1;
        check("rst_req_ready", {63'h0, req_ready}, 64'h1);
        check("rst_res_valid", {63'h0, res_valid}, 64'h0);
        check("rst_product", {32'h0, res_product}, 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        mul(16'h0003, 16'h0005, 32'h0000_000F, 0);
        mul(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0);
        mul(16'h1234, 16'h0000, 32'h0000_0000, 0);
        mul(16'h0000, 16'hABCD, 32'h0000_0000, 0);
        mul(16'h8000, 16'h8000, 32'h4000_0000, 1);
        mul(16'h1234, 16'h5678, 32'h0626_0060, 10);

        // Abort mid-operation with an asynchronous reset pulse.
        req_a     = 16'h00FF;
        req_b     = 16'h0101;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_req_ready", {63'h0, req_ready}, 64'h1);
        check("abort_res_valid", {63'h0, res_valid}, 64'h0);
        check("abort_product", {32'h0, res_product}, 64'h0);
        check("abort_alu", {29'h0, alu_args, alu_carry_in, alu_carry_dis, alu_cmd}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mul(16'h0002, 16'h0003, 32'h0000_0006, 0);

        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 17 == 0) ra = 16'hFFFF;
            mul(ra, rb, 32'(ra) * 32'(rb), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
